// File: rtl/jzjpcc_uart_pkg.sv
// Shared types and constants for the MMIO UART.
// Holds the tx/rx state enums, the status word layout and the bit positions
// software uses for the command and status registers.
package jzjpcc_uart_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned STATUS_W         = 32;
    localparam int unsigned CMD_TOGGLE       = 8;
    localparam int unsigned STATUS_TX_ACK    = 8;
    localparam int unsigned STATUS_TX_BUSY   = 9;
    localparam int unsigned STATUS_RX_TOGGLE = 10;
    localparam int unsigned STATUS_RX_FERR   = 11;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAITHIGH
    } rxState_t;

    // Status word as seen on mmioInputs; field order matches the STATUS_* positions.
    typedef struct packed {
        logic [STATUS_W-13:0] zero;
        logic                 rxFerr;
        logic                 rxToggle;
        logic                 txBusy;
        logic                 txAck;
        logic [DATA_W-1:0]    rxByte;
    } status_t;

endpackage

// File: rtl/jzjpcc_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, rx FSM and publish registers.
// Ports:
//   clock, reset   core clock, async active-high reset
//   rxd            asynchronous serial input
//   rxByte         last received byte
//   rxToggle       flips on every published byte (including framing errors)
//   rxFerr         stop bit of last byte was low
module jzjpcc_uart_rx
    import jzjpcc_uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 434
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] rxByte,
    output logic              rxToggle,
    output logic              rxFerr
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

    logic rxSync1, rxSync2, rxPrev;

    rxState_t          state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [2:0]        idx, idxNext;
    logic [DATA_W-1:0] shift, shiftNext;
    logic [DATA_W-1:0] byteNext;
    logic              toggleNext, ferrNext;

    // Synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            rxPrev  <= 1'b1;
        end else begin
            rxSync1 <= rxd;
            rxSync2 <= rxSync1;
            rxPrev  <= rxSync2;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            rxByte   <= '0;
            rxToggle <= 1'b0;
            rxFerr   <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            idx      <= idxNext;
            shift    <= shiftNext;
            rxByte   <= byteNext;
            rxToggle <= toggleNext;
            rxFerr   <= ferrNext;
        end
    end

    // Next-state and publish logic.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        idxNext    = idx;
        shiftNext  = shift;
        byteNext   = rxByte;
        toggleNext = rxToggle;
        ferrNext   = rxFerr;
        case (state)
            RX_IDLE: begin
                if (rxPrev && !rxSync2) begin
                    stateNext = RX_START;
                    cntNext   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rxSync2) begin
                        stateNext = RX_DATA;
                        cntNext   = CNT_FULL;
                        idxNext   = 3'd0;
                    end else begin
                        stateNext = RX_IDLE;
                    end
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shiftNext = {rxSync2, shift[DATA_W-1:1]};
                    cntNext   = CNT_FULL;
                    if (idx == 3'd7) begin
                        stateNext = RX_STOP;
                    end else begin
                        idxNext = idx + 3'd1;
                    end
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    byteNext   = shift;
                    ferrNext   = !rxSync2;
                    toggleNext = !rxToggle;
                    // A low stop bit must see the line return high before re-arming.
                    stateNext  = rxSync2 ? RX_IDLE : RX_WAITHIGH;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            RX_WAITHIGH: begin
                if (rxSync2) begin
                    stateNext = RX_IDLE;
                end
            end
            default: stateNext = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/jzjpcc_mmio_uart.sv
// Memory-mapped 8N1 UART sitting beside the core's MMIO registers.
// Handshakes use toggle bits since MMIO registers carry no strobes.
// Optional receiver compiled in when JZJPCC_UART_RX_EN is defined; otherwise
// rxd is unused and the rx status fields read 0.
// Ports:
//   clock, reset   core clock, async active-high reset
//   txCommand      [7:0] byte to send, [8] send toggle, rest ignored
//   status         [7:0] rx byte, [8] tx ack, [9] tx busy, [10] rx toggle,
//                  [11] rx framing error, [31:12] zero
//   rxd            serial input (asynchronous)
//   txd            serial output, idles high
module jzjpcc_mmio_uart
    import jzjpcc_uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 434
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [STATUS_W-1:0] txCommand,
    output logic [STATUS_W-1:0] status,
    input  logic                rxd,
    output logic                txd
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_BIT - 1);

    txState_t          txState, txStateNext;
    logic [CNT_W-1:0]  txCnt, txCntNext;
    logic [2:0]        txIdx, txIdxNext;
    logic [DATA_W-1:0] txShift, txShiftNext;
    logic              txAck, txAckNext;
    logic              txBusy, txBusyNext;
    logic              txdNext;
    logic              txPending;

    logic [DATA_W-1:0] rxByte;
    logic              rxToggle, rxFerr;
    status_t           statusWord;

    logic [STATUS_W-CMD_TOGGLE-2:0] unusedCmdBits;
    assign unusedCmdBits = txCommand[STATUS_W-1:CMD_TOGGLE+1];

    assign txPending = txCommand[CMD_TOGGLE] != txAck;

    // Tx state and datapath registers; txd resets to the idle level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txIdx   <= '0;
            txShift <= '0;
            txAck   <= 1'b0;
            txBusy  <= 1'b0;
            txd     <= 1'b1;
        end else begin
            txState <= txStateNext;
            txCnt   <= txCntNext;
            txIdx   <= txIdxNext;
            txShift <= txShiftNext;
            txAck   <= txAckNext;
            txBusy  <= txBusyNext;
            txd     <= txdNext;
        end
    end

    // Tx next-state logic; txd is computed one step ahead so it is registered.
    always_comb begin
        txStateNext = txState;
        txCntNext   = txCnt;
        txIdxNext   = txIdx;
        txShiftNext = txShift;
        txAckNext   = txAck;
        txBusyNext  = txBusy;
        txdNext     = txd;
        case (txState)
            TX_IDLE: begin
                txdNext = 1'b1;
                if (txPending) begin
                    txStateNext = TX_START;
                    txShiftNext = txCommand[DATA_W-1:0];
                    txAckNext   = txCommand[CMD_TOGGLE];
                    txBusyNext  = 1'b1;
                    txdNext     = 1'b0;
                    txCntNext   = CNT_FULL;
                end
            end
            TX_START: begin
                if (txCnt == '0) begin
                    txStateNext = TX_DATA;
                    txCntNext   = CNT_FULL;
                    txIdxNext   = 3'd0;
                    txdNext     = txShift[0];
                end else begin
                    txCntNext = txCnt - CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (txCnt == '0) begin
                    txCntNext = CNT_FULL;
                    if (txIdx == 3'd7) begin
                        txStateNext = TX_STOP;
                        txdNext     = 1'b1;
                    end else begin
                        txIdxNext   = txIdx + 3'd1;
                        txShiftNext = {1'b0, txShift[DATA_W-1:1]};
                        txdNext     = txShift[1];
                    end
                end else begin
                    txCntNext = txCnt - CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (txCnt == '0) begin
                    txStateNext = TX_IDLE;
                    txBusyNext  = 1'b0;
                end else begin
                    txCntNext = txCnt - CNT_W'(1);
                end
            end
            default: begin
                txStateNext = TX_IDLE;
                txdNext     = 1'b1;
            end
        endcase
    end

`ifdef JZJPCC_UART_RX_EN
    jzjpcc_uart_rx #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) uRx (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rxByte   (rxByte),
        .rxToggle (rxToggle),
        .rxFerr   (rxFerr)
    );
`else
    logic unusedRxd;
    assign unusedRxd = rxd;
    assign rxByte    = '0;
    assign rxToggle  = 1'b0;
    assign rxFerr    = 1'b0;
`endif

    // Status is assembled purely from registers.
    always_comb begin
        statusWord          = '0;
        statusWord.rxByte   = rxByte;
        statusWord.txAck    = txAck;
        statusWord.txBusy   = txBusy;
        statusWord.rxToggle = rxToggle;
        statusWord.rxFerr   = rxFerr;
    end

    assign status = statusWord;

endmodule

// File: tb/tb_jzjpcc_mmio_uart.sv
// Directed self-checking bench for jzjpcc_mmio_uart with CLOCKS_PER_BIT = 4.
module tb_jzjpcc_mmio_uart;

    localparam int unsigned CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] txCommand = 32'h0;
    logic [31:0] status;
    logic        rxd = 1'b1;
    logic        txd;

    int cmpCount = 0;
    int errCount = 0;
    logic rxTogExp = 1'b0;

    always #5 clock = ~clock;

    jzjpcc_mmio_uart #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .txCommand (txCommand),
        .status    (status),
        .rxd       (rxd),
        .txd       (txd)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        txCommand = 32'h0;
        rxd = 1'b1;
        rxTogExp = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_rx_frame(input logic [7:0] data, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clock);
                rxd = bits[4'(b)];
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        txCommand = 32'h0;
        rxd = 1'b1;
        #1;
        cmpCount++;
        if (txd !== 1'b1) begin
            errCount++;
            $display("FAIL reset_txd: got %b want 1", txd);
        end
        cmpCount++;
        if (status !== 32'h0) begin
            errCount++;
            $display("FAIL reset_status: got %h want 00000000", status);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        cmpCount++;
        if (status !== 32'h0 || txd !== 1'b1) begin
            errCount++;
            $display("FAIL post_reset_idle: status %h txd %b want 00000000 1", status, txd);
        end
    endtask

    task automatic test_single_send();
        logic [9:0] frame;
        logic [2:0] got, exp;
        do_reset();
        frame = {1'b1, 8'h55, 1'b0};
        cmpCount++;
        if (status[8] !== 1'b0) begin
            errCount++;
            $display("FAIL single_ack_before: got %b want 0", status[8]);
        end
        txCommand = 32'h155;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            got = {txd, status[9], status[8]};
            exp = {frame[4'(i / 4)], 1'b1, 1'b1};
            cmpCount++;
            if (got !== exp) begin
                errCount++;
                $display("FAIL single_frame cyc %0d: txd/busy/ack got %b want %b", i, got, exp);
            end
            // Data change after acceptance must not disturb the byte in flight.
            if (i == 6) txCommand = 32'h1FF;
        end
        @(negedge clock);
        got = {txd, status[9], status[8]};
        cmpCount++;
        if (got !== 3'b101) begin
            errCount++;
            $display("FAIL single_end: txd/busy/ack got %b want 101", got);
        end
        @(negedge clock);
        cmpCount++;
        if (txd !== 1'b1 || status[9] !== 1'b0) begin
            errCount++;
            $display("FAIL single_no_resend: txd %b busy %b want 1 0", txd, status[9]);
        end
    endtask

    task automatic test_queued_send();
        logic [9:0] frameA, frameB;
        logic [2:0] got, exp;
        do_reset();
        frameA = {1'b1, 8'h41, 1'b0};
        frameB = {1'b1, 8'h42, 1'b0};
        txCommand = 32'h141;
        for (int i = 0; i < 82; i++) begin
            @(negedge clock);
            if (i < 40)       exp = {frameA[4'(i / 4)], 1'b1, 1'b1};
            else if (i == 40) exp = 3'b101;
            else if (i < 81)  exp = {frameB[4'((i - 41) / 4)], 1'b1, 1'b0};
            else              exp = 3'b100;
            got = {txd, status[9], status[8]};
            cmpCount++;
            if (got !== exp) begin
                errCount++;
                $display("FAIL queued_frame cyc %0d: txd/busy/ack got %b want %b", i, got, exp);
            end
            if (i == 5) txCommand = 32'h042;
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        txCommand = 32'h1AA;
        @(negedge clock);
        cmpCount++;
        if (txd !== 1'b0) begin
            errCount++;
            $display("FAIL midreset_start: txd got %b want 0", txd);
        end
        reset = 1'b1;
        #1;
        cmpCount++;
        if (txd !== 1'b1 || status !== 32'h0) begin
            errCount++;
            $display("FAIL midreset_async: txd %b status %h want 1 00000000", txd, status);
        end
        @(negedge clock);
        reset = 1'b0;
        txCommand = 32'h0;
        @(negedge clock);
        @(negedge clock);
        cmpCount++;
        if (txd !== 1'b1 || status !== 32'h0) begin
            errCount++;
            $display("FAIL midreset_after: txd %b status %h want 1 00000000", txd, status);
        end
    endtask

`ifdef JZJPCC_UART_RX_EN
    task automatic test_receive();
        bit seen;
        do_reset();
        repeat (3) @(negedge clock);
        drive_rx_frame(8'hA5, 1'b1);
        rxd = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            if (status[10] !== rxTogExp) seen = 1'b1;
        end
        rxTogExp = ~rxTogExp;
        cmpCount++;
        if (!seen) begin
            errCount++;
            $display("FAIL rx_publish_timeout: toggle got %b want %b", status[10], rxTogExp);
        end
        cmpCount++;
        if (status[11:0] !== {1'b0, rxTogExp, 2'b00, 8'hA5}) begin
            errCount++;
            $display("FAIL rx_a5: status got %h want %h", status[11:0], {1'b0, rxTogExp, 2'b00, 8'hA5});
        end
        repeat (20) @(negedge clock);
        cmpCount++;
        if (status[10] !== rxTogExp) begin
            errCount++;
            $display("FAIL rx_single_publish: toggle got %b want %b", status[10], rxTogExp);
        end
    endtask

    task automatic test_framing_glitch();
        bit seen;
        drive_rx_frame(8'h3C, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            if (status[10] !== rxTogExp) seen = 1'b1;
        end
        rxTogExp = ~rxTogExp;
        cmpCount++;
        if (!seen || status[11] !== 1'b1 || status[7:0] !== 8'h3C) begin
            errCount++;
            $display("FAIL rx_ferr: seen %0d ferr %b byte %h want 1 1 3c", seen, status[11], status[7:0]);
        end
        repeat (30) @(negedge clock);
        cmpCount++;
        if (status[10] !== rxTogExp) begin
            errCount++;
            $display("FAIL rx_waithigh: toggle got %b want %b", status[10], rxTogExp);
        end
        rxd = 1'b1;
        repeat (3) @(negedge clock);
        drive_rx_frame(8'h5A, 1'b1);
        rxd = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            if (status[10] !== rxTogExp) seen = 1'b1;
        end
        rxTogExp = ~rxTogExp;
        cmpCount++;
        if (!seen || status[11] !== 1'b0 || status[7:0] !== 8'h5A) begin
            errCount++;
            $display("FAIL rx_after_ferr: seen %0d ferr %b byte %h want 1 0 5a", seen, status[11], status[7:0]);
        end
        @(negedge clock);
        rxd = 1'b0;
        @(negedge clock);
        rxd = 1'b1;
        repeat (40) @(negedge clock);
        cmpCount++;
        if (status[10] !== rxTogExp || status[7:0] !== 8'h5A) begin
            errCount++;
            $display("FAIL rx_glitch: toggle %b byte %h want %b 5a", status[10], status[7:0], rxTogExp);
        end
    endtask
`else
    task automatic test_rx_disabled();
        do_reset();
        repeat (3) @(negedge clock);
        drive_rx_frame(8'h3C, 1'b1);
        rxd = 1'b1;
        repeat (20) @(negedge clock);
        cmpCount++;
        if (status[11:10] !== 2'b00 || status[7:0] !== 8'h00) begin
            errCount++;
            $display("FAIL rx_disabled: status[11:0] got %h want 000", status[11:0]);
        end
        cmpCount++;
        if (status !== 32'h0) begin
            errCount++;
            $display("FAIL rx_disabled_word: status got %h want 00000000", status);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_send();
        test_queued_send();
        test_reset_mid_frame();
`ifdef JZJPCC_UART_RX_EN
        test_receive();
        test_framing_glitch();
`else
        test_rx_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/jzjpcc_mmio_uart.md
# jzjpcc_mmio_uart

Memory-mapped serial port that sits directly beside the core: its command input is driven by one of the core's `mmioOutputs` registers, and its status word drives the matching `mmioInputs` entry. It provides a buffered-by-one 8N1 transmitter and an 8N1 receiver. Handshakes use toggle bits, because MMIO registers carry no write or read strobes.

## Interface
- `CLOCKS_PER_BIT`, default 434; clock cycles per serial bit; minimum 4.
- `clock`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `txCommand`  in  32  from `mmioOutputs[k]`:
  - [7:0] byte to send
  - [8] send toggle
  - [31:9] ignored
- `status`  out  32  to `mmioInputs[k]`:
  - [7:0] last received byte
  - [8] tx ack toggle
  - [9] tx busy
  - [10] rx toggle
  - [11] rx framing error of last byte
  - [31:12] zero
- `rxd`  in  1  serial input; asynchronous to `clock`.
- `txd`  out  1  serial output; idles high.

## Operation
- Reset state:
  - `txd` = 1.
  - `status` = 0.
  - Tx ack toggle = 0.
  - Both FSMs are in IDLE.
- **Tx request rule:** a send is pending whenever `txCommand[8]` differs from the ack toggle (`status[8]`).
  - Software flips bit 8 while it writes the data.
  - Software knows the byte was taken when `status[8]` equals its own bit.
- **Tx FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when a send is pending: latch `txCommand[7:0]`, set ack = `txCommand[8]`, set busy = 1.
  - START drives `txd` = 0 for `CLOCKS_PER_BIT` cycles.
  - DATA drives the 8 bits LSB first, `CLOCKS_PER_BIT` cycles each, counted by a 3-bit index.
  - STOP drives `txd` = 1 for `CLOCKS_PER_BIT` cycles, then → IDLE with busy = 0.
- **Tx edge cases:**
  - A toggle change during START, DATA or STOP stays pending and is accepted in IDLE. At most one request is outstanding.
  - Changing `txCommand[7:0]` after acceptance has no effect on the byte being sent.
- **Rx input:** `rxd` passes through a 2-flop synchronizer.
- **Rx FSM states:** IDLE, START, DATA, STOP, WAITHIGH.
  - IDLE → START on a synchronized high→low transition.
  - START waits `CLOCKS_PER_BIT/2` cycles, then samples. Low → DATA. High → IDLE (false start, nothing published).
  - DATA samples every `CLOCKS_PER_BIT` cycles, 8 samples, LSB first.
  - STOP samples after `CLOCKS_PER_BIT` cycles.
- **Rx publish (at the STOP sample):**
  - `status[7:0]` = the received byte.
  - `status[11]` = inverse of the stop sample.
  - `status[10]` flips.
  - Next state: stop sample high → IDLE; stop sample low → WAITHIGH, which returns to IDLE once the synchronized `rxd` is high.
- **Rx overrun:** unread bytes are overwritten. The rx toggle still flips, so software detects missed bytes only by counting toggles.
- **Counters:** the bit counter is `$clog2(CLOCKS_PER_BIT)` bits wide and counts down to 0, reloading on each bit.

## Timing
- **Tx request to start bit:** a toggle difference visible before edge N → `txd` low, ack updated and busy high, all after edge N (1 cycle).
- **Tx frame length:** exactly `10*CLOCKS_PER_BIT` cycles from `txd` falling to busy clearing.
- **Back-to-back tx:** when a request is pending at the end of STOP, the next start bit begins on the following edge, giving a 1-cycle IDLE between frames.
- **Rx latency:** publish happens `2 + CLOCKS_PER_BIT/2 + 9*CLOCKS_PER_BIT` cycles (±1) after the `rxd` falling edge.
- **`status` timing:** `status` is fully registered; there is no combinational path from `txCommand` or `rxd` to `status`.
- **Reset mid-frame:** immediately forces `txd` = 1 and clears all status bits. The partial frame is abandoned.
- **Simultaneous events:** tx and rx are independent and may update `status` bits on the same edge.

## Configuration
- `JZJPCC_UART_RX_EN` defined: the receiver, synchronizer and `status[7:0]`, `[10]`, `[11]` are compiled in.
- `JZJPCC_UART_RX_EN` undefined:
  - The receiver is not instantiated and `rxd` is unused.
  - `status[7:0]`, `[10]` and `[11]` read constant 0.
  - The transmitter is unchanged.

## Structure
- Package `jzjpcc_uart_pkg` holds:
  - the tx and rx state enums;
  - status bit-position constants (`STATUS_TX_ACK = 8`, `STATUS_TX_BUSY = 9`, `STATUS_RX_TOGGLE = 10`, `STATUS_RX_FERR = 11`);
  - the command toggle position (8).
- Sub-module `jzjpcc_uart_rx` contains the synchronizer, rx FSM and publish registers.
  - It is instantiated under `JZJPCC_UART_RX_EN`.
  - The tx FSM stays in the top module.

## Test plan
All scenarios use `CLOCKS_PER_BIT` = 4.
- **Reset:** assert `reset` with `txCommand` = 0 → `txd` = 1, `status` = 0. Assert `reset` mid-frame → `txd` = 1 within the same cycle.
- **Single send:** `txCommand` = 0x155 → `txd` shows 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles. `status[8]` = 1 one cycle after the change, and `status[9]` = 1 for 40 cycles.
- **Queued send:** write 0x141 (toggle → 1), then 0x042 (toggle → 0) while busy → 'A' and 'B' frames sent with a 1-cycle gap. Final `status[8]` = 0.
- **Receive:** drive an 8N1 0xA5 frame on `rxd` → `status[7:0]` = 0xA5, `status[10]` flips, `status[11]` = 0.
- **Framing error and glitch:**
  - A frame with low stop bit → `status[11]` = 1, and no new start is detected until `rxd` returns high.
  - A 1-cycle low glitch → no publish.
- **Macro undefined:** drive a 0x3C frame on `rxd` → `status[11:10]` = 0 and `status[7:0]` = 0; tx still operates as in the single-send scenario.
